// File: rtl/z_move_sched_pkg.sv
// ---------------------------------------------------------------------------
// z_move_sched_pkg
// Shared definitions for the Z-axis move scheduler:
//   - CMD_W               : width of one queued command record {steps, speed}
//   - DEFAULT_DEPTH       : default command FIFO depth
//   - DEFAULT_ACK_TIMEOUT : default cycles allowed for the stepper to ack a start
//   - move_state_t        : scheduler FSM state encoding (also exported as dbg_state)
//   - cmd_is_valid()      : a command is runnable only with non-zero magnitude and speed
// ---------------------------------------------------------------------------
package z_move_sched_pkg;

    localparam int CMD_W               = 64;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_ACK_TIMEOUT = 2;
    localparam int STATE_W             = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_START    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } move_state_t;

    // Record layout: [63] direction, [62:32] step magnitude, [31:0] half-period.
    function automatic logic cmd_is_valid(input logic [CMD_W-1:0] cmd);
        return (cmd[62:32] != '0) && (cmd[31:0] != '0);
    endfunction

endpackage

// File: rtl/z_move_sched_cmd_fifo.sv
// ---------------------------------------------------------------------------
// z_cmd_fifo
// Synchronous command FIFO with flush and occupancy count.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   push, push_data   : write request; ignored when full, during flush or reset
//   pop               : drop the head entry; ignored when empty or during flush
//   flush             : empty the FIFO on this edge (wins over push and pop)
//   head              : entry at the read pointer (valid when !empty)
//   count, empty      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module z_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && reset_n && !flush && (count < CW'(DEPTH));
    assign do_pop  = pop && reset_n && !flush && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/z_move_sched.sv
// ---------------------------------------------------------------------------
// z_move_sched
// Queues Z-axis move commands from a host and issues them one at a time to a
// stepper driver, tracking ack, completion, stalls and rejected commands.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   cmd_valid/cmd_ready          : host enqueue handshake
//   cmd_steps, cmd_speed         : {dir, magnitude[30:0]} and half-period
//   abort                        : pulse, flushes the queue (running move continues)
//   stepper_step_in/_speed       : move currently presented to the stepper
//   start_driving                : one-cycle start strobe
//   stepper_enable               : equals busy
//   stepper_driving, _step_out   : stepper status and residual step count
//   busy, done_pulse             : activity and one-cycle move-complete strobe
//   stall_flag, reject_flag      : sticky; cleared by reset or an IDLE write
//   queue_count, last_remaining  : occupancy, residual magnitude of last move
//   dbg_state                    : current FSM state (move_state_t encoding)
//
// Handshake: a command is written on a rising edge where cmd_valid and
// cmd_ready are both 1 and abort is 0. cmd_ready depends only on queue_count,
// never on cmd_valid, so the host may hold cmd_valid until it sees cmd_ready.
// The running move's command stays at the FIFO head until DONE (or a reject)
// pops it, so it is included in queue_count.
// ---------------------------------------------------------------------------
module z_move_sched
    import z_move_sched_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ACK_TIMEOUT    = DEFAULT_ACK_TIMEOUT,
    parameter int FLUSH_ON_STALL = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_steps,
    input  logic [31:0]              cmd_speed,
    input  logic                     abort,
    output logic [31:0]              stepper_step_in,
    output logic [31:0]              stepper_speed,
    output logic                     start_driving,
    output logic                     stepper_enable,
    input  logic                     stepper_driving,
    input  logic [31:0]              stepper_step_out,
    output logic                     busy,
    output logic                     done_pulse,
    output logic                     stall_flag,
    output logic                     reject_flag,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [30:0]              last_remaining,
    output logic [STATE_W-1:0]       dbg_state
);

    localparam int          CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam bit          FLUSH_EN = (FLUSH_ON_STALL != 0);

    move_state_t      state;
    logic [15:0]      wait_cnt;
    // Set while the running move's command is still the FIFO head; a flush
    // removes it, and the later pop must then not consume a newer command.
    logic             owns_head;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             head_ok;
    logic             ack_expired;
    logic             stalled_now;
    logic             unused_step_out_dir;

    assign cmd_ready      = (queue_count < CNT_W'(DEPTH));
    assign fifo_push      = cmd_valid && cmd_ready && !abort;
    assign head_ok        = cmd_is_valid(fifo_head);
    assign ack_expired    = (state == S_WAIT_ACK) && !stepper_driving && (wait_cnt == ACK_LAST);
    assign stalled_now    = (state == S_DONE) && (stepper_step_out[30:0] != '0);
    assign fifo_flush     = abort || (stalled_now && FLUSH_EN);
    assign fifo_pop       = ((state == S_LOAD) && !fifo_empty && !head_ok)
                          || (ack_expired && owns_head)
                          || ((state == S_DONE) && owns_head);
    assign busy           = (state != S_IDLE) || (queue_count != '0);
    assign stepper_enable = busy;
    assign dbg_state      = state;
    // Only the residual magnitude matters; its direction bit is not used.
    assign unused_step_out_dir = stepper_step_out[31];

    z_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({cmd_steps, cmd_speed}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (queue_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            owns_head       <= 1'b0;
            start_driving   <= 1'b0;
            done_pulse      <= 1'b0;
            stepper_step_in <= '0;
            stepper_speed   <= '0;
            last_remaining  <= '0;
            stall_flag      <= 1'b0;
            reject_flag     <= 1'b0;
        end else begin
            start_driving <= 1'b0;
            done_pulse    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fifo_push) begin
                        stall_flag  <= 1'b0;
                        reject_flag <= 1'b0;
                    end
                    if (!fifo_empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    // An abort in the IDLE cycle can leave nothing to load.
                    if (fifo_empty) begin
                        state <= S_IDLE;
                    end else begin
                        stepper_step_in <= fifo_head[63:32];
                        stepper_speed   <= fifo_head[31:0];
                        if (!head_ok) begin
                            reject_flag <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            start_driving <= 1'b1;
                            owns_head     <= 1'b1;
                            state         <= S_START;
                        end
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (stepper_driving) begin
                        state <= S_RUN;
                    end else if (ack_expired) begin
                        // Stepper refused to start (e.g. endstop): drop the move.
                        reject_flag <= 1'b1;
                        owns_head   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!stepper_driving) begin
                        done_pulse <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_remaining <= stepper_step_out[30:0];
                    if (stalled_now) stall_flag <= 1'b1;
                    owns_head <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Abort empties the FIFO, so the running move no longer has a head.
            if (abort) owns_head <= 1'b0;
        end
    end

endmodule

// File: tb/tb_z_move_sched.sv
module tb_z_move_sched;
    import z_move_sched_pkg::*;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 2;
    localparam int CW          = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [31:0]     cmd_steps = '0;
    logic [31:0]     cmd_speed = '0;
    logic            abort = 1'b0;
    logic [31:0]     stepper_step_in, stepper_speed;
    logic            start_driving, stepper_enable;
    logic            stepper_driving = 1'b0;
    logic [31:0]     stepper_step_out = '0;
    logic            busy, done_pulse, stall_flag, reject_flag;
    logic [CW-1:0]   queue_count;
    logic [30:0]     last_remaining;
    logic [2:0]      dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    z_move_sched #(
        .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .FLUSH_ON_STALL(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_speed(cmd_speed), .abort(abort),
        .stepper_step_in(stepper_step_in), .stepper_speed(stepper_speed),
        .start_driving(start_driving), .stepper_enable(stepper_enable),
        .stepper_driving(stepper_driving), .stepper_step_out(stepper_step_out),
        .busy(busy), .done_pulse(done_pulse), .stall_flag(stall_flag),
        .reject_flag(reject_flag), .queue_count(queue_count),
        .last_remaining(last_remaining), .dbg_state(dbg_state)
    );

    // ---------------- stepper stub + event monitor ----------------
    // Each start_driving consumes one behaviour entry: ack or not, how many
    // cycles to drive, and the step_out word left when driving falls.
    typedef struct {
        bit          ack;
        int          run_len;
        logic [31:0] out_val;
    } stub_t;

    stub_t       stub_q[$];
    stub_t       stub_cur;
    int          stub_left = 0;
    logic [31:0] stub_out = '0;
    int          cyc = 0;
    int          start_times[$];
    int          fall_times[$];
    logic [30:0] done_log[$];
    logic [30:0] exp_q[$];
    int          n_done = 0;
    int          t_reject = -1;
    bit          prev_done = 0;
    bit          prev_reject = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_done) done_log.push_back(last_remaining);
        prev_done = done_pulse;
        if (done_pulse) n_done = n_done + 1;
        if (reject_flag && !prev_reject) t_reject = cyc;
        prev_reject = reject_flag;
        if (stub_left > 0) begin
            stub_left = stub_left - 1;
            if (stub_left == 0) begin
                stepper_driving  = 1'b0;
                stepper_step_out = stub_out;
                fall_times.push_back(cyc);
            end
        end
        if (start_driving) begin
            start_times.push_back(cyc);
            if (stub_q.size() > 0) begin
                stub_cur = stub_q.pop_front();
                if (stub_cur.ack) begin
                    stepper_driving  = 1'b1;
                    stepper_step_out = 32'h7FFF_FFFF;
                    stub_left        = stub_cur.run_len;
                    stub_out         = stub_cur.out_val;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic add_stub(input bit ack, input int run_len, input logic [31:0] out_val);
        stub_t e;
        e.ack = ack;
        e.run_len = run_len;
        e.out_val = out_val;
        stub_q.push_back(e);
    endtask

    task automatic clear_logs();
        start_times.delete();
        fall_times.delete();
        done_log.delete();
        stub_q.delete();
        exp_q.delete();
        n_done = 0;
        t_reject = -1;
    endtask

    // Called at a negedge; returns whether the write will be accepted.
    task automatic push_cmd(input logic [31:0] s, input logic [31:0] sp, output bit acc);
        cmd_valid = 1'b1;
        cmd_steps = s;
        cmd_speed = sp;
        acc = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        @(negedge clk);
        while ((busy || stepper_driving) && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = busy || stepper_driving;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_driving(input int budget, output bit timed_out);
        int n = 0;
        while (!stepper_driving && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = !stepper_driving;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run += 4;
        if ({start_driving, stepper_enable, busy, done_pulse, stall_flag, reject_flag, cmd_ready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, required 0000001", {start_driving, stepper_enable, busy, done_pulse, stall_flag, reject_flag, cmd_ready});
        end
        if (queue_count !== CW'(0)) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d, required 0", queue_count);
        end
        if ({stepper_step_in, stepper_speed} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_move: got %h, required 0", {stepper_step_in, stepper_speed});
        end
        if (last_remaining !== 31'd0) begin
            tests_failed++;
            $display("FAIL reset_remaining: got %0d, required 0", last_remaining);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_move();
        bit acc, to;
        clear_logs();
        add_stub(1'b1, 80, 32'h0);
        push_cmd(32'd10, 32'd4, acc);
        wait_idle(300, to);
        tests_run += 7;
        if (to || !acc) begin tests_failed++; $display("FAIL single_flow: timeout=%0b accepted=%0b, required 0/1", to, acc); end
        if (start_times.size() != 1) begin tests_failed++; $display("FAIL single_starts: got %0d, required 1", start_times.size()); end
        if (n_done != 1) begin tests_failed++; $display("FAIL single_done: got %0d, required 1", n_done); end
        if (last_remaining !== 31'd0) begin tests_failed++; $display("FAIL single_remaining: got %0d, required 0", last_remaining); end
        if (stall_flag !== 1'b0 || reject_flag !== 1'b0) begin tests_failed++; $display("FAIL single_flags: stall=%b reject=%b, required 0 0", stall_flag, reject_flag); end
        if (stepper_step_in !== 32'd10 || stepper_speed !== 32'd4) begin tests_failed++; $display("FAIL single_move_regs: got %0d/%0d, required 10/4", stepper_step_in, stepper_speed); end
        if (busy !== 1'b0 || stepper_enable !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got %b/%b, required 0/0", busy, stepper_enable); end
    endtask

    task automatic test_invalid_cmd();
        bit acc, to;
        clear_logs();
        push_cmd(32'h8000_0000, 32'd5, acc);   // zero magnitude
        push_cmd(32'd7, 32'd0, acc);           // zero speed
        wait_idle(100, to);
        tests_run += 4;
        if (to) begin tests_failed++; $display("FAIL invalid_timeout: still busy, required idle"); end
        if (start_times.size() != 0 || n_done != 0) begin tests_failed++; $display("FAIL invalid_started: starts=%0d done=%0d, required 0 0", start_times.size(), n_done); end
        if (reject_flag !== 1'b1) begin tests_failed++; $display("FAIL invalid_reject: got %b, required 1", reject_flag); end
        if (stepper_step_in !== 32'd7 || queue_count !== CW'(0)) begin tests_failed++; $display("FAIL invalid_regs: step_in=%0d count=%0d, required 7 0", stepper_step_in, queue_count); end
    endtask

    task automatic test_fill();
        bit acc, to;
        int n_acc = 0;
        bit last_acc = 0;
        clear_logs();
        add_stub(1'b1, 150, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_cmd(32'(i + 1), 32'd3, acc);
            if (acc) n_acc++;
            last_acc = acc;
        end
        tests_run += 3;
        if (n_acc != DEPTH || last_acc != 1'b0) begin tests_failed++; $display("FAIL fill_accepted: got %0d (9th=%0b), required %0d (9th=0)", n_acc, last_acc, DEPTH); end
        if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready: got %b, required 0", cmd_ready); end
        if (queue_count !== CW'(DEPTH)) begin tests_failed++; $display("FAIL fill_count: got %0d, required %0d", queue_count, DEPTH); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run += 2;
        if (queue_count !== CW'(0) || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_abort: count=%0d ready=%b, required 0 1", queue_count, cmd_ready); end
        wait_idle(400, to);
        if (to || n_done != 1) begin tests_failed++; $display("FAIL fill_drain: timeout=%0b done=%0d, required 0 1", to, n_done); end
    endtask

    task automatic test_ack_timeout();
        bit acc, to;
        clear_logs();
        add_stub(1'b0, 0, 32'h0);
        add_stub(1'b1, 6, 32'h0);
        push_cmd(32'd20, 32'd2, acc);
        push_cmd(32'd21, 32'd2, acc);
        wait_idle(200, to);
        tests_run += 5;
        if (to) begin tests_failed++; $display("FAIL ack_timeout_idle: still busy, required idle"); end
        if (start_times.size() != 2) begin tests_failed++; $display("FAIL ack_next_issued: starts=%0d, required 2", start_times.size()); end
        // START cycle, then ACK_TIMEOUT cycles of waiting, then the flag is visible.
        if (start_times.size() < 1 || t_reject - start_times[0] != ACK_TIMEOUT + 1) begin
            tests_failed++;
            $display("FAIL ack_reject_time: got %0d cycles after start, required %0d", (start_times.size() < 1) ? -1 : t_reject - start_times[0], ACK_TIMEOUT + 1);
        end
        if (reject_flag !== 1'b1 || n_done != 1) begin tests_failed++; $display("FAIL ack_reject_done: reject=%b done=%0d, required 1 1", reject_flag, n_done); end
        if (queue_count !== CW'(0)) begin tests_failed++; $display("FAIL ack_count: got %0d, required 0", queue_count); end
    endtask

    task automatic test_back_to_back();
        bit acc, to;
        clear_logs();
        add_stub(1'b1, 5, 32'h0);
        add_stub(1'b1, 5, 32'h0);
        push_cmd(32'd30, 32'd1, acc);
        push_cmd(32'd31, 32'd1, acc);
        wait_idle(200, to);
        tests_run += 2;
        if (to || n_done != 2 || start_times.size() != 2) begin tests_failed++; $display("FAIL b2b_counts: timeout=%0b done=%0d starts=%0d, required 0 2 2", to, n_done, start_times.size()); end
        // DONE, IDLE, LOAD after driving falls, then START shows the strobe.
        if (start_times.size() < 2 || fall_times.size() < 1 || start_times[1] - fall_times[0] != 3 + 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %0d, required 4", (start_times.size() < 2 || fall_times.size() < 1) ? -1 : start_times[1] - fall_times[0]);
        end
    endtask

    task automatic test_stall();
        bit acc, to;
        clear_logs();
        add_stub(1'b1, 6, 32'h8000_0005);
        add_stub(1'b1, 6, 32'h0);
        add_stub(1'b1, 6, 32'h0);
        for (int i = 0; i < 3; i++) push_cmd(32'd40, 32'd2, acc);
        wait_idle(200, to);
        tests_run += 4;
        if (to) begin tests_failed++; $display("FAIL stall_idle: still busy, required idle"); end
        if (stall_flag !== 1'b1 || last_remaining !== 31'd5) begin tests_failed++; $display("FAIL stall_result: stall=%b rem=%0d, required 1 5", stall_flag, last_remaining); end
        if (queue_count !== CW'(0)) begin tests_failed++; $display("FAIL stall_flush: count=%0d, required 0", queue_count); end
        if (start_times.size() != 1 || n_done != 1) begin tests_failed++; $display("FAIL stall_moves: starts=%0d done=%0d, required 1 1", start_times.size(), n_done); end
    endtask

    task automatic test_abort();
        bit acc, to;
        clear_logs();
        add_stub(1'b1, 40, 32'h0000_0002);
        for (int i = 0; i < 4; i++) push_cmd(32'd50, 32'd2, acc);
        wait_driving(50, to);
        repeat (2) @(negedge clk);
        tests_run += 6;
        if (to || queue_count !== CW'(4)) begin tests_failed++; $display("FAIL abort_pre: timeout=%0b count=%0d, required 0 4", to, queue_count); end
        // A write coinciding with abort must be dropped.
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_steps = 32'd9;
        cmd_speed = 32'd1;
        @(negedge clk);
        abort = 1'b0;
        cmd_valid = 1'b0;
        if (queue_count !== CW'(0)) begin tests_failed++; $display("FAIL abort_flush: count=%0d, required 0", queue_count); end
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_move_kept: busy=%b, required 1", busy); end
        wait_idle(200, to);
        if (to || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_end_busy: timeout=%0b busy=%b, required 0 0", to, busy); end
        if (n_done != 1 || start_times.size() != 1) begin tests_failed++; $display("FAIL abort_moves: done=%0d starts=%0d, required 1 1", n_done, start_times.size()); end
        if (last_remaining !== 31'd2 || stall_flag !== 1'b1) begin tests_failed++; $display("FAIL abort_remaining: rem=%0d stall=%b, required 2 1", last_remaining, stall_flag); end
    endtask

    task automatic test_reset_mid_run();
        bit acc, to;
        clear_logs();
        add_stub(1'b1, 30, 32'h0);
        push_cmd(32'd60, 32'd2, acc);
        push_cmd(32'd61, 32'd2, acc);
        wait_driving(50, to);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        tests_run += 6;
        if (to) begin tests_failed++; $display("FAIL rst_run_start: stepper never driving, required driving"); end
        if ({start_driving, stepper_enable, busy, done_pulse, stall_flag, reject_flag, cmd_ready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL rst_run_ctrl: got %b, required 0000001", {start_driving, stepper_enable, busy, done_pulse, stall_flag, reject_flag, cmd_ready});
        end
        if (queue_count !== CW'(0) || last_remaining !== 31'd0) begin tests_failed++; $display("FAIL rst_run_state: count=%0d rem=%0d, required 0 0", queue_count, last_remaining); end
        if ({stepper_step_in, stepper_speed} !== 64'd0) begin tests_failed++; $display("FAIL rst_run_move: got %h, required 0", {stepper_step_in, stepper_speed}); end
        reset_n = 1'b1;
        clear_logs();
        repeat (40) @(negedge clk);
        if (n_done != 0 || start_times.size() != 0) begin tests_failed++; $display("FAIL rst_run_ignored: done=%0d starts=%0d, required 0 0", n_done, start_times.size()); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_run_busy: got %b, required 0", busy); end
    endtask

    // Reference model: walk the commands in order. Invalid commands and
    // un-acked starts reject; acked moves complete with the stub's residual;
    // a non-zero residual stalls and discards everything still queued.
    task automatic test_random();
        bit acc, to;
        int n, run;
        bit ack, valid, stopped, exp_rej, exp_stall;
        int exp_starts;
        logic [31:0] s, sp, outv;
        logic [31:0] cs[$];
        logic [31:0] cp[$];
        for (int it = 0; it < 10; it++) begin
            clear_logs();
            cs.delete();
            cp.delete();
            n = $urandom_range(2, 6);
            stopped = 0; exp_rej = 0; exp_stall = 0; exp_starts = 0;
            for (int i = 0; i < n; i++) begin
                s = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 1000))};
                sp = 32'($urandom_range(1, 20));
                ack = 1'b1;
                run = $urandom_range(4, 12);
                outv = 32'h0;
                if (i > 0) begin
                    if ($urandom_range(0, 4) == 0) s = {s[31], 31'd0};
                    if ($urandom_range(0, 4) == 0) sp = 32'd0;
                    ack = ($urandom_range(0, 4) != 0);
                    if ($urandom_range(0, 3) == 0) outv = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 100))};
                end else if ($urandom_range(0, 5) == 0) begin
                    outv = 32'($urandom_range(1, 100));
                end
                cs.push_back(s);
                cp.push_back(sp);
                valid = (s[30:0] != 31'd0) && (sp != 32'd0);
                if (valid) add_stub(ack, run, outv);
                if (!stopped) begin
                    if (!valid) exp_rej = 1;
                    else begin
                        exp_starts++;
                        if (!ack) exp_rej = 1;
                        else begin
                            exp_q.push_back(outv[30:0]);
                            if (outv[30:0] != 31'd0) begin exp_stall = 1; stopped = 1; end
                        end
                    end
                end
            end
            for (int i = 0; i < n; i++) push_cmd(cs[i], cp[i], acc);
            wait_idle(500, to);
            tests_run += 5;
            if (to) begin tests_failed++; $display("FAIL rand%0d_idle: still busy, required idle", it); end
            if (start_times.size() != exp_starts) begin tests_failed++; $display("FAIL rand%0d_starts: got %0d, required %0d", it, start_times.size(), exp_starts); end
            if (reject_flag !== exp_rej || stall_flag !== exp_stall) begin tests_failed++; $display("FAIL rand%0d_flags: reject=%b stall=%b, required %b %b", it, reject_flag, stall_flag, exp_rej, exp_stall); end
            if (done_log.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_ndone: got %0d, required %0d", it, done_log.size(), exp_q.size()); end
            if (queue_count !== CW'(0)) begin tests_failed++; $display("FAIL rand%0d_count: got %0d, required 0", it, queue_count); end
            for (int k = 0; k < exp_q.size() && k < done_log.size(); k++) begin
                tests_run++;
                if (done_log[k] !== exp_q[k]) begin tests_failed++; $display("FAIL rand%0d_rem%0d: got %0d, required %0d", it, k, done_log[k], exp_q[k]); end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_single_move();
        test_invalid_cmd();
        test_fill();
        test_ack_timeout();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
